// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//   Central hazard/stall sequencer for the 5-stage pipeline. Produces the
//   enable and synchronous-flush controls for the PC and the FD/DX/XM/MW
//   pipeline registers, and sequences the multicycle divider: a start pulse,
//   a front-end freeze while the divider runs, and one DONE cycle during which
//   the div instruction advances into XM together with its result.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous, active-high; clears FSM and counter
//   div_start_req    in   instruction in execute is mul/div
//   div_ready        in   divider result valid (looked at only in DIV_WAIT)
//   load_use_hazard  in   decode consumes a load destination held in execute
//   branch_taken     in   execute resolved a taken branch/jump
//   div_start        out  one-cycle start pulse to the divider
//   div_busy         out  FSM in START or DIV_WAIT
//   div_timeout      out  one-cycle pulse when the wait budget expires
//   pc/fd/dx/xm/mw_enable  out  register write enables
//   fd/dx/xm_flush   out  load a nop into that register on the next edge
//
// Parameters
//   DIV_LATENCY  max DIV_WAIT cycles before a timeout (must be >= 2)
//   CNT_W        wait counter width, 2**CNT_W > DIV_LATENCY
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic div_start_req,
  input  logic div_ready,
  input  logic load_use_hazard,
  input  logic branch_taken,
  output logic div_start,
  output logic div_busy,
  output logic div_timeout,
  output logic pc_enable,
  output logic fd_enable,
  output logic dx_enable,
  output logic xm_enable,
  output logic mw_enable,
  output logic fd_flush,
  output logic dx_flush,
  output logic xm_flush
);

  typedef enum logic [1:0] {IDLE, START, DIV_WAIT, DONE} state_t;

  // Per-stage control bundle; every legal pattern below keeps flush=1 only
  // where the matching enable is also 1.
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_fl;
    logic dx_fl;
    logic xm_fl;
  } stage_ctl_t;

  // Everything flows.
  localparam stage_ctl_t CTL_RUN     = '{pc_en:1'b1, fd_en:1'b1, dx_en:1'b1, xm_en:1'b1,
                                         mw_en:1'b1, fd_fl:1'b0, dx_fl:1'b0, xm_fl:1'b0};
  // Taken branch: squash the two younger instructions already fetched/decoded.
  localparam stage_ctl_t CTL_BRANCH  = '{pc_en:1'b1, fd_en:1'b1, dx_en:1'b1, xm_en:1'b1,
                                         mw_en:1'b1, fd_fl:1'b1, dx_fl:1'b1, xm_fl:1'b0};
  // Load-use: hold PC and FD, insert a bubble into DX.
  localparam stage_ctl_t CTL_LOADUSE = '{pc_en:1'b0, fd_en:1'b0, dx_en:1'b1, xm_en:1'b1,
                                         mw_en:1'b1, fd_fl:1'b0, dx_fl:1'b1, xm_fl:1'b0};
  // Divide in flight: freeze the front end with the div held in DX, feed
  // bubbles into XM, and let older instructions drain through MW.
  localparam stage_ctl_t CTL_FREEZE  = '{pc_en:1'b0, fd_en:1'b0, dx_en:1'b0, xm_en:1'b1,
                                         mw_en:1'b1, fd_fl:1'b0, dx_fl:1'b0, xm_fl:1'b1};

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  stage_ctl_t       ctl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Counts DIV_WAIT cycles already spent: 0 on the first wait cycle, so the
  // value CNT_LAST marks the final permitted wait cycle. Saturates rather
  // than wrapping so a stuck FSM can never alias back to a small count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (state == START)                    cnt <= '0;
    else if (state == DIV_WAIT && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    state_next  = state;
    ctl         = CTL_RUN;
    div_start   = 1'b0;
    div_busy    = 1'b0;
    div_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_start_req) begin
          div_start  = 1'b1;
          ctl        = CTL_FREEZE;
          state_next = START;
        end else if (branch_taken) begin
          ctl = CTL_BRANCH;
        end else if (load_use_hazard) begin
          ctl = CTL_LOADUSE;
        end
      end
      START: begin
        div_busy   = 1'b1;
        ctl        = CTL_FREEZE;
        state_next = DIV_WAIT;
      end
      DIV_WAIT: begin
        div_busy = 1'b1;
        ctl      = CTL_FREEZE;
        // A result arriving on the last budgeted cycle still counts as good.
        if (div_ready) begin
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          div_timeout = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        // The div is still in DX this cycle, so its request is not a new one.
        state_next = IDLE;
        if (branch_taken)         ctl = CTL_BRANCH;
        else if (load_use_hazard) ctl = CTL_LOADUSE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_enable = ctl.pc_en;
  assign fd_enable = ctl.fd_en;
  assign dx_enable = ctl.dx_en;
  assign xm_enable = ctl.xm_en;
  assign mw_enable = ctl.mw_en;
  assign fd_flush  = ctl.fd_fl;
  assign dx_flush  = ctl.dx_fl;
  assign xm_flush  = ctl.xm_fl;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int DIV_LATENCY = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic div_start_req = 1'b0, div_ready = 1'b0, load_use_hazard = 1'b0, branch_taken = 1'b0;
  logic div_start, div_busy, div_timeout;
  logic pc_enable, fd_enable, dx_enable, xm_enable, mw_enable;
  logic fd_flush, dx_flush, xm_flush;

  pipeline_stall_controller #(.DIV_LATENCY(DIV_LATENCY), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .div_start_req(div_start_req), .div_ready(div_ready),
    .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .div_start(div_start), .div_busy(div_busy), .div_timeout(div_timeout),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .dx_enable(dx_enable),
    .xm_enable(xm_enable), .mw_enable(mw_enable),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush)
  );

  always #5 clock = ~clock;

  // {div_start, div_busy, div_timeout, pc, fd, dx, xm, mw, fd_fl, dx_fl, xm_fl}
  logic [10:0] outs;
  assign outs = {div_start, div_busy, div_timeout, pc_enable, fd_enable, dx_enable,
                 xm_enable, mw_enable, fd_flush, dx_flush, xm_flush};

  localparam logic [10:0] O_RESET = 11'b000_11111_000;

  int checks = 0;
  int failures = 0;
  logic [10:0] o;

  // Model: cycles elapsed since the div was accepted (-1 = no divide in
  // flight; 1 = start cycle; k>=2 = wait cycle number k-1), plus a flag for
  // the single release cycle that follows the divide.
  int m_since = -1;
  bit m_done  = 1'b0;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Output rules written straight from the stage behaviour: mode 0 = normal
  // flow, 1 = divide being issued, 2 = divider running, 3 = release cycle.
  function automatic logic [10:0] model_out(input int mode, input bit tmo, input bit lu, input bit br);
    logic [10:0] r;
    case (mode)
      1:       r = 11'b100_00011_001;
      2:       r = {2'b01, tmo, 8'b00011_001};
      default: r = br ? 11'b000_11111_110 : (lu ? 11'b000_00111_010 : 11'b000_11111_000);
    endcase
    return r;
  endfunction

  // One cycle: drive, compare against model mid-cycle, advance model.
  task automatic step(input bit rq, input bit rd, input bit lu, input bit br);
    int  mode;
    bit  tmo;
    div_start_req = rq; div_ready = rd; load_use_hazard = lu; branch_taken = br;
    #3;
    tmo = 1'b0;
    if (m_done)          mode = 3;
    else if (m_since < 0) mode = rq ? 1 : 0;
    else begin
      mode = 2;
      tmo  = (m_since >= 2) && (m_since - 1 == DIV_LATENCY) && !rd;
    end
    o = outs;
    check("cycle_model", o, model_out(mode, tmo, lu, br));
    if (m_done) m_done = 1'b0;
    else if (m_since < 0) begin
      if (rq) m_since = 1;
    end else if (m_since == 1) m_since = 2;
    else if (rd || (m_since - 1 == DIV_LATENCY)) begin
      m_since = -1; m_done = 1'b1;
    end else m_since++;
    @(posedge clock); #1;
  endtask

  // Assert reset away from any edge, confirm the asynchronous effect, then
  // release just after an edge.
  task automatic apply_reset();
    div_start_req = 0; div_ready = 0; load_use_hazard = 0; branch_taken = 0;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", outs, O_RESET);
    m_since = -1; m_done = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Divide with no result ever: returns timeout cycle and pulse count.
  task automatic run_timeout(output int tmo_cyc, output int pulses, output bit done_ok);
    tmo_cyc = -1; pulses = 0; done_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(c == 0, 0, 0, 0);
      if (o[8]) begin pulses++; if (tmo_cyc < 0) tmo_cyc = c; end
      if (c == 34) done_ok = (o == O_RESET);
    end
  endtask

  initial begin
    int tc, np, done_cyc, starts;
    bit dok;

    apply_reset();

    // Quiet pipeline after reset.
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 0);
      if (c == 9) check("idle_after_reset", o, O_RESET);
    end

    // Divide with result on cycle 5.
    done_cyc = -1; starts = 0;
    for (int c = 0; c < 8; c++) begin
      step(c == 0, c == 5, 0, 0);
      if (o[10]) starts++;
      if (c >= 1 && c <= 5) check("div_freeze", {o[7:5], o[0]}, 4'b0001);
      if (c > 0 && !o[9] && done_cyc < 0) done_cyc = c;
    end
    check("div_start_pulses", 11'(starts), 11'd1);
    check("div_done_cycle", 11'(done_cyc), 11'd6);

    // Divide that times out.
    run_timeout(tc, np, dok);
    check("timeout_cycle", 11'(tc), 11'd33);
    check("timeout_pulses", 11'(np), 11'd1);
    check("timeout_then_done", 11'(dok), 11'd1);

    // Both hazards in normal flow: the branch wins.
    step(0, 0, 1, 1);
    check("branch_over_loaduse", o, 11'b000_11111_110);
    step(0, 0, 1, 0);
    check("loaduse_bubble", o, 11'b000_00111_010);

    // Branch during wait is ignored, branch held into release cycle flushes.
    for (int c = 0; c < 7; c++) begin
      step(c == 0, c == 5, 0, (c == 3) || (c >= 5));
      if (c == 3) check("branch_in_wait_no_flush", {9'b0, o[2:1]}, 11'd0);
      if (c == 6) check("branch_in_done_flush", o, 11'b000_11111_110);
    end
    step(0, 0, 0, 0);

    // Reset in the middle of a wait (counter at 10).
    for (int c = 0; c < 12; c++) step(c == 0, 0, 0, 0);
    apply_reset();
    run_timeout(tc, np, dok);
    check("timeout_cycle_after_reset", 11'(tc), 11'd33);
    check("timeout_pulses_after_reset", 11'(np), 11'd1);

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) apply_reset();
      else step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline.
- Drives the enable and flush inputs of the PC, fetch/decode, decode/execute, execute/memory and memory/writeback registers.
- Sequences the multicycle divider: start pulse, then freeze front end until result.
- Handles load-use stalls and taken-branch squashes, so the pipeline registers stay plain enable/clear storage.

Parameters:
- DIV_LATENCY, 32, max cycles in DIV_WAIT before a timeout is declared (>=2).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and counter.
- div_start_req  in  1  instruction in execute is mul/div (decoded from DX instruction).
- div_ready  in  1  divider result valid (level; sampled only in DIV_WAIT).
- load_use_hazard  in  1  decode consumes the destination of a load in execute.
- branch_taken  in  1  execute resolved a taken branch/jump.
- div_start  out  1  one-cycle start pulse to divider.
- div_busy  out  1  FSM in START or DIV_WAIT.
- div_timeout  out  1  one-cycle pulse when DIV_LATENCY expires without div_ready.
- pc_enable, fd_enable, dx_enable, xm_enable, mw_enable  out  1 each  register write enables.
- fd_flush, dx_flush, xm_flush  out  1 each  load nop into that register on next edge (synchronous; distinct from reset).

Behaviour:
- Outputs are combinational from state and inputs. FSM and counter are the only flops, both asynchronously reset.
- States: IDLE, START, DIV_WAIT, DONE.
- Reset value (state IDLE, inputs low): all enables 1, all flushes 0, div_start 0, div_busy 0, div_timeout 0, counter 0.
- IDLE, priority div_start_req > branch_taken > load_use_hazard > none:
  - div_start_req: next = START. This cycle: div_start=1; pc/fd/dx enables 0; xm_enable 1 with xm_flush 1; mw_enable 1.
  - branch_taken: all enables 1, fd_flush 1, dx_flush 1.
  - load_use_hazard: pc_enable 0, fd_enable 0, dx_enable 1 with dx_flush 1, xm/mw enables 1.
  - none: all enables 1, flushes 0.
- START, one cycle: div_busy 1; front end frozen as above (xm nop, mw enabled); counter cleared; next = DIV_WAIT. div_ready ignored.
- DIV_WAIT: div_busy 1; same freeze pattern; counter increments each cycle.
  - div_ready=1: next = DONE.
  - counter == DIV_LATENCY-1 with div_ready=0: div_timeout=1 this cycle; next = DONE.
  - If both occur the same cycle, div_ready wins: no timeout.
- DONE, one cycle: all enables 1, flushes 0, so the div instruction advances to XM with its result. div_start_req is ignored (same instruction). branch_taken and load_use_hazard are evaluated as in IDLE except the div arm. next = IDLE.
- Latency: div instruction leaves execute exactly 3 + N cycles after entering IDLE with div_start_req, where N = DIV_WAIT cycles (1..DIV_LATENCY).
- branch_taken and load_use_hazard are ignored during START and DIV_WAIT (execute/decode frozen; re-evaluated in DONE).
- No stage ever sees enable=0 and flush=1 together.
- Reset asserted mid-divide: immediate return to IDLE, outputs at reset values, no div_start and no timeout pulse. The divider is reset by the same net.
- Counter saturates; it never wraps.

Test Plan:
- Reset release with all inputs 0 -> all five enables 1, flushes 0, div_busy 0 for 10 cycles.
- div_start_req=1 at cycle 0, div_ready=1 at cycle 5 ->
  - div_start high cycle 0 only.
  - pc/fd/dx enables 0 and xm_flush 1 on cycles 0-5.
  - DONE at cycle 6 with all enables 1; IDLE at cycle 7.
- div_start_req, div_ready never asserted, DIV_LATENCY=32 -> div_timeout pulses exactly at the 32nd DIV_WAIT cycle; DONE the next cycle; no second pulse.
- load_use_hazard and branch_taken both 1 in IDLE -> fd_flush=1, dx_flush=1, pc_enable=1, fd_enable=1.
- branch_taken pulsed during DIV_WAIT -> no flush asserted. Held through DONE -> fd_flush=dx_flush=1 in DONE.
- reset asserted in DIV_WAIT at counter=10 -> outputs at reset values asynchronously. After release, a new div_start_req produces a fresh div_start and the full wait count restarts from 0.
